ram_bus_master: RTL and testbench
=================================

Name: ram_bus_master

Overview:
- Bus initiator for the shared tri-state data BUS and the single-port RAM behind it.
- Accepts one read or write request at a time from the core over a valid/ready handshake.
- Sequences the RAM control strobes: MAR address, BUS_READ (RAM captures the bus) and BUS_WRITE_n (RAM drives the bus).
- Returns read data, or a write acknowledge, on a valid/ready response channel.

Parameters:
- DATA_WIDTH, 8, width of BUS and data words.
- ADDRESS_WIDTH, 4, width of the MAR address (16-entry RAM).

Ports:
- i_CLOCK  input  1  system clock; all state changes on the rising edge.
- i_RESET_n  input  1  asynchronous, active-low reset.
- i_REQ_VALID  input  1  request present.
- o_REQ_READY  output  1  master can accept a request.
- i_REQ_WRITE  input  1  1 = write, 0 = read.
- i_REQ_ADDR  input  ADDRESS_WIDTH  target address.
- i_REQ_WDATA  input  DATA_WIDTH  write data.
- o_RSP_VALID  output  1  response present.
- i_RSP_READY  input  1  core accepts the response.
- o_RSP_RDATA  output  DATA_WIDTH  read data, or readback data.
- o_RSP_ERR  output  1  readback mismatch flag.
- BUS  inout  DATA_WIDTH  shared tri-state data bus.
- o_MAR_DATA  output  ADDRESS_WIDTH  address to the RAM.
- o_BUS_READ  output  1  RAM captures BUS on the next rising edge.
- o_BUS_WRITE_n  output  1  active-low; RAM drives BUS.

Behaviour:
- Reset (asynchronous, immediate, also mid-transaction):
  - state = IDLE.
  - o_REQ_READY = 1; o_RSP_VALID = 0; o_RSP_RDATA = 0; o_RSP_ERR = 0.
  - o_MAR_DATA = 0; o_BUS_READ = 0; o_BUS_WRITE_n = 1.
  - BUS released (high-Z).
  - No partial write may complete after reset is asserted.
- All outputs are registered. BUS drive enable is registered.
- FSM states: IDLE, SETUP, XFER, RESP. VSETUP and VXFER exist only with the optional feature.
- IDLE:
  - o_REQ_READY = 1.
  - On the edge with i_REQ_VALID & o_REQ_READY: latch write flag and wdata; load o_MAR_DATA = i_REQ_ADDR; go to SETUP.
- SETUP (1 cycle, MAR settles):
  - Write: BUS driven with wdata; o_BUS_READ = 0.
  - Read: o_BUS_WRITE_n = 0; BUS released.
  - Go to XFER.
- XFER (1 cycle):
  - Write: BUS still driven; o_BUS_READ = 1, so the RAM stores on the closing edge.
  - Read: o_BUS_WRITE_n = 0; BUS is sampled into o_RSP_RDATA on the closing edge.
  - Go to RESP, or to VSETUP (optional feature, writes only).
- On leaving XFER: o_BUS_READ = 0, o_BUS_WRITE_n = 1, BUS released.
- RESP:
  - o_RSP_VALID = 1; o_RSP_RDATA and o_RSP_ERR are held stable.
  - Hold until i_RSP_READY is high at an edge, then go to IDLE with o_RSP_VALID = 0.
  - Write response without the feature: o_RSP_RDATA = wdata, o_RSP_ERR = 0.
- o_REQ_READY = 0 in every state except IDLE. Only one request is outstanding.
- Latency: request accept to o_RSP_VALID = 3 edges (accept, SETUP, XFER). Back-to-back throughput is 1 transaction per 4 cycles when i_RSP_READY is held high.
- Contention invariant:
  - The master never drives BUS while o_BUS_WRITE_n = 0.
  - o_BUS_READ and !o_BUS_WRITE_n are never high together.
  - BUS is high-Z in IDLE and RESP.
- Input changes on i_REQ_* after acceptance are ignored. All request fields are captured at accept.
- i_RSP_READY high with o_RSP_VALID low has no effect.
- Address wrap: no arithmetic is performed; the address is passed through as given.

Optional Feature:
- Macro: RAM_BUS_MASTER_READBACK_EN.
- Defined:
  - After a write XFER, go to VSETUP, then VXFER. These are identical to the read SETUP/XFER at the same address.
  - VXFER samples BUS into o_RSP_RDATA.
  - o_RSP_ERR = 1 if the readback differs from the written data, else 0.
  - Write latency becomes 5 edges. Reads are unchanged.
  - The contention invariant still holds: BUS is released in VSETUP.
- Undefined:
  - No V* states exist.
  - o_RSP_ERR is constant 0.
  - The write response returns wdata as o_RSP_RDATA.

Test Plan:
- Write addr 4'h3, data 8'hA5, i_RSP_READY = 1 → o_BUS_READ high exactly 1 cycle with BUS = 8'hA5 and o_MAR_DATA = 3; o_RSP_VALID on the 3rd edge after accept; RAM[3] = 8'hA5.
- Read addr 4'h3 after that write → o_BUS_WRITE_n low for 2 cycles; master BUS driver high-Z throughout; o_RSP_RDATA = 8'hA5 with o_RSP_VALID.
- Hold i_RSP_READY = 0 for 5 cycles after a read of addr 4'hF (RAM = 8'h5C) → o_RSP_VALID and o_RSP_RDATA = 8'h5C stable; o_REQ_READY = 0; a new request is not accepted until the cycle after the response handshake.
- Assert i_RESET_n = 0 asynchronously mid-XFER of a write to addr 4'h7 → o_BUS_READ = 0, o_BUS_WRITE_n = 1, BUS high-Z, o_REQ_READY = 1 immediately; RAM[7] unchanged.
- Back-to-back write 4'h0 = 8'h11, then read 4'h0 → responses 8'h11 and 8'h11; contention checker (master drive & !o_BUS_WRITE_n) never fires.
- With RAM_BUS_MASTER_READBACK_EN, force RAM bit 0 of addr 4'h2 stuck at 0, write 8'hFF → o_RSP_RDATA = 8'hFE, o_RSP_ERR = 1, response on the 5th edge.

Source files
------------

// File: rtl/ram_bus_master.sv
// ----------------------------------------------------------------------------
// ram_bus_master
//
// Purpose:
//   Bus initiator for the shared tri-state data BUS and the single-port RAM
//   behind it. Takes one read or write request at a time from the core,
//   sequences the RAM strobes (MAR address, BUS_READ, BUS_WRITE_n) and returns
//   read data or a write acknowledge on a response channel.
//
// Handshakes (both channels): a transfer happens on a rising edge where
//   valid and ready are both high. The producer holds its valid and payload
//   stable until that edge. The consumer may raise or drop ready freely.
//   o_REQ_READY is high only in IDLE. o_RSP_VALID is high only in RESP, and
//   o_RSP_RDATA / o_RSP_ERR stay stable while it is high.
//
// Transaction timeline (edges counted from the accept edge):
//   write : SETUP (master drives BUS) -> XFER (BUS_READ=1, RAM stores) -> RESP
//   read  : SETUP (BUS_WRITE_n=0)     -> XFER (BUS sampled)            -> RESP
//   With RAM_BUS_MASTER_READBACK_EN defined, a write continues
//   XFER -> VSETUP -> VXFER, which read the same address back and compare it.
//
// Optional feature macro: RAM_BUS_MASTER_READBACK_EN
//   undefined : no V* states; o_RSP_ERR is constant 0; a write response
//               returns the written data.
//   defined   : a write is verified by readback; o_RSP_ERR flags a mismatch.
//
// Ports:
//   i_CLOCK        system clock, rising edge
//   i_RESET_n      asynchronous active-low reset
//   i_REQ_VALID    request present
//   o_REQ_READY    master can accept a request
//   i_REQ_WRITE    1 = write, 0 = read
//   i_REQ_ADDR     target address
//   i_REQ_WDATA    write data
//   o_RSP_VALID    response present
//   i_RSP_READY    core accepts the response
//   o_RSP_RDATA    read data or readback/write data
//   o_RSP_ERR      readback mismatch flag
//   BUS            shared tri-state data bus
//   o_MAR_DATA     address to the RAM
//   o_BUS_READ     RAM captures BUS on the next rising edge
//   o_BUS_WRITE_n  active-low: RAM drives BUS
//   o_DBG_STATE    current FSM state encoding (debug observation only)
// ----------------------------------------------------------------------------
module ram_bus_master #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     i_CLOCK,
    input  logic                     i_RESET_n,
    input  logic                     i_REQ_VALID,
    output logic                     o_REQ_READY,
    input  logic                     i_REQ_WRITE,
    input  logic [ADDRESS_WIDTH-1:0] i_REQ_ADDR,
    input  logic [DATA_WIDTH-1:0]    i_REQ_WDATA,
    output logic                     o_RSP_VALID,
    input  logic                     i_RSP_READY,
    output logic [DATA_WIDTH-1:0]    o_RSP_RDATA,
    output logic                     o_RSP_ERR,
    inout  wire  [DATA_WIDTH-1:0]    BUS,
    output logic [ADDRESS_WIDTH-1:0] o_MAR_DATA,
    output logic                     o_BUS_READ,
    output logic                     o_BUS_WRITE_n,
    output logic [2:0]               o_DBG_STATE
);

`ifdef RAM_BUS_MASTER_READBACK_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_XFER   = 3'd2,
        S_RESP   = 3'd3,
        S_VSETUP = 3'd4,
        S_VXFER  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_RESP  = 3'd3
    } state_t;
`endif

    state_t                   r_state;
    logic                     r_req_ready;
    logic                     r_rsp_valid;
    logic [DATA_WIDTH-1:0]    r_rsp_rdata;
    logic [ADDRESS_WIDTH-1:0] r_mar;
    logic                     r_bus_read;
    logic                     r_bus_write_n;
    logic                     r_drive_en;   // registered BUS output enable
    logic                     r_is_write;
    logic [DATA_WIDTH-1:0]    r_wdata;
`ifdef RAM_BUS_MASTER_READBACK_EN
    logic                     r_rsp_err;
`endif

    // The drive enable is only ever set while BUS_WRITE_n is high, and both
    // change on the same edge, so the master and the RAM never overlap.
    assign BUS = r_drive_en ? r_wdata : {DATA_WIDTH{1'bz}};

    always_ff @(posedge i_CLOCK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_mar         <= '0;
            r_bus_read    <= 1'b0;
            r_bus_write_n <= 1'b1;
            r_drive_en    <= 1'b0;
            r_is_write    <= 1'b0;
            r_wdata       <= '0;
`ifdef RAM_BUS_MASTER_READBACK_EN
            r_rsp_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_REQ_VALID && r_req_ready) begin
                        // Capture every request field now; later changes are ignored.
                        r_is_write    <= i_REQ_WRITE;
                        r_wdata       <= i_REQ_WDATA;
                        r_mar         <= i_REQ_ADDR;
                        r_req_ready   <= 1'b0;
                        // Write: drive the bus during SETUP. Read: let the RAM drive.
                        r_drive_en    <= i_REQ_WRITE;
                        r_bus_write_n <= i_REQ_WRITE;
                        r_state       <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    // MAR has settled; a write now strobes the RAM capture.
                    r_bus_read <= r_is_write;
                    r_state    <= S_XFER;
                end

                S_XFER: begin
                    r_bus_read <= 1'b0;
                    r_drive_en <= 1'b0;
                    if (r_is_write) begin
`ifdef RAM_BUS_MASTER_READBACK_EN
                        // Release the bus and ask the RAM to drive it back.
                        r_bus_write_n <= 1'b0;
                        r_state       <= S_VSETUP;
`else
                        r_rsp_rdata   <= r_wdata;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= S_RESP;
`endif
                    end else begin
                        r_bus_write_n <= 1'b1;
                        r_rsp_rdata   <= BUS;
                        r_rsp_valid   <= 1'b1;
`ifdef RAM_BUS_MASTER_READBACK_EN
                        r_rsp_err     <= 1'b0;
`endif
                        r_state       <= S_RESP;
                    end
                end

`ifdef RAM_BUS_MASTER_READBACK_EN
                S_VSETUP: begin
                    r_state <= S_VXFER;
                end

                S_VXFER: begin
                    r_bus_write_n <= 1'b1;
                    r_rsp_rdata   <= BUS;
                    r_rsp_err     <= (BUS != r_wdata);
                    r_rsp_valid   <= 1'b1;
                    r_state       <= S_RESP;
                end
`endif

                S_RESP: begin
                    if (i_RSP_READY) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state       <= S_IDLE;
                    r_req_ready   <= 1'b1;
                    r_rsp_valid   <= 1'b0;
                    r_bus_read    <= 1'b0;
                    r_bus_write_n <= 1'b1;
                    r_drive_en    <= 1'b0;
                end
            endcase
        end
    end

    assign o_REQ_READY   = r_req_ready;
    assign o_RSP_VALID   = r_rsp_valid;
    assign o_RSP_RDATA   = r_rsp_rdata;
    assign o_MAR_DATA    = r_mar;
    assign o_BUS_READ    = r_bus_read;
    assign o_BUS_WRITE_n = r_bus_write_n;
    assign o_DBG_STATE   = r_state;
`ifdef RAM_BUS_MASTER_READBACK_EN
    assign o_RSP_ERR     = r_rsp_err;
`else
    assign o_RSP_ERR     = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
`timescale 1ns/1ps
module tb_ram_bus_master;
    localparam int DW = 8;
    localparam int AW = 4;
`ifdef RAM_BUS_MASTER_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_ready = 1'b0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mar;
    logic          bus_read;
    logic          bus_write_n;
    logic [2:0]    dbg_state;
    wire  [DW-1:0] bus;

    ram_bus_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .i_CLOCK(clk), .i_RESET_n(rst_n),
        .i_REQ_VALID(req_valid), .o_REQ_READY(req_ready),
        .i_REQ_WRITE(req_write), .i_REQ_ADDR(req_addr), .i_REQ_WDATA(req_wdata),
        .o_RSP_VALID(rsp_valid), .i_RSP_READY(rsp_ready),
        .o_RSP_RDATA(rsp_rdata), .o_RSP_ERR(rsp_err),
        .BUS(bus), .o_MAR_DATA(mar), .o_BUS_READ(bus_read),
        .o_BUS_WRITE_n(bus_write_n), .o_DBG_STATE(dbg_state)
    );

    // ---------------- RAM behind the bus ----------------
    logic [DW-1:0] ram_mem  [16];
    logic [DW-1:0] ram_init [16];
    logic          ram_load = 1'b0;
    logic          stuck_en = 1'b0;   // bit 0 of address 2 reads as 0

    function automatic logic [DW-1:0] ram_view(input logic [DW-1:0] v, input logic [AW-1:0] a,
                                               input logic stk);
        return (stk && a == 4'h2) ? (v & 8'hFE) : v;
    endfunction

    assign bus = bus_write_n ? {DW{1'bz}} : ram_view(ram_mem[mar], mar, stuck_en);

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= ram_init[i];
        end else if (bus_read) begin
            ram_mem[mar] <= bus;
        end
    end

    function automatic bit released(input logic [DW-1:0] b);
        for (int i = 0; i < DW; i++)
            if (b[i] !== 1'b0 && b[i] !== 1'bz) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [DW:0] exp_q[$];   // {err, rdata} per response, in order

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Transaction-level: phase counts edges since the accept edge.
    // Phase 1/2 are the two bus cycles, lat is when the response appears.
    logic          m_busy;
    int            m_phase;
    int            m_lat;
    logic          m_write;
    logic [AW-1:0] m_mar;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_err;
    logic [DW-1:0] m_mem [16];

    always @(posedge clk or negedge rst_n) begin
        if (ram_load)
            for (int i = 0; i < 16; i++) m_mem[i] = ram_init[i];
        if (!rst_n) begin
            m_busy = 1'b0; m_phase = 0; m_lat = 3; m_write = 1'b0;
            m_mar = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy  = 1'b1;
                m_phase = 1;
                m_write = req_write;
                m_mar   = req_addr;
                m_wdata = req_wdata;
                m_lat   = (req_write && READBACK) ? 5 : 3;
            end
        end else if (m_phase == m_lat) begin
            if (rsp_ready) begin
                m_busy  = 1'b0;
                m_phase = 0;
            end
        end else begin
            if (m_phase == 2 && m_write) m_mem[m_mar] = m_wdata;
            m_phase++;
            if (m_phase == m_lat) begin
                if (m_write && !READBACK) begin
                    m_rdata = m_wdata;
                    m_err   = 1'b0;
                end else begin
                    m_rdata = ram_view(m_mem[m_mar], m_mar, stuck_en);
                    m_err   = m_write && (m_rdata != m_wdata);
                end
                exp_q.push_back({m_err, m_rdata});
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            logic ram_ph, drv_ph;
            ram_ph = m_busy && ((!m_write && (m_phase == 1 || m_phase == 2)) ||
                                (m_write && READBACK && (m_phase == 3 || m_phase == 4)));
            drv_ph = m_busy && m_write && (m_phase == 1 || m_phase == 2);
            check("cyc_req_ready", req_ready, !m_busy);
            check("cyc_rsp_valid", rsp_valid, m_busy && m_phase == m_lat);
            check("cyc_mar", mar, m_mar);
            check("cyc_bus_read", bus_read, m_busy && m_write && m_phase == 2);
            check("cyc_bus_write_n", bus_write_n, !ram_ph);
            check("cyc_rsp_rdata", rsp_rdata, m_rdata);
            check("cyc_rsp_err", rsp_err, m_err);
            check("cyc_no_strobe_overlap", bus_read && !bus_write_n, 1'b0);
            if (drv_ph)      check("cyc_bus_master", bus, m_wdata);
            else if (ram_ph) check("cyc_bus_ram", bus, ram_view(m_mem[m_mar], m_mar, stuck_en));
            else             check("cyc_bus_released", released(bus), 1'b1);
        end
    end

    // ---------------- driver ----------------
    task automatic do_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int hold, output logic [DW-1:0] rdata, output logic err,
                          output int lat, output int br_cyc, output int wn_cyc);
        int n;
        logic [DW:0] exp;
        n = 0;
        rdata = '0; err = 1'b0; lat = 0; br_cyc = 0; wn_cyc = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("req_ready_wait", req_ready, 1'b1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        // Scramble the request bus after accept; it must be ignored.
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = 4'($urandom); req_wdata = 8'($urandom);
        lat = 1; br_cyc = int'(bus_read); wn_cyc = int'(!bus_write_n);
        while (!rsp_valid && lat < 20) begin
            rsp_ready = 1'($urandom);
            @(posedge clk); #1;
            lat++; br_cyc += int'(bus_read); wn_cyc += int'(!bus_write_n);
        end
        rsp_ready = 1'b0;
        check("rsp_valid_seen", rsp_valid, 1'b1);
        if (!rsp_valid) return;
        rdata = rsp_rdata;
        err   = rsp_err;
        if (exp_q.size() == 0) begin
            check("rsp_queue_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check("rsp_vs_model", {rsp_err, rsp_rdata}, exp);
        end
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_write = 1'($urandom); req_addr = 4'($urandom); req_wdata = 8'($urandom);
            @(posedge clk); #1;
            check("hold_req_ready", req_ready, 1'b0);
            check("hold_rsp_rdata", rsp_rdata, rdata);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("hs_rsp_valid_low", rsp_valid, 1'b0);
        check("hs_req_ready_high", req_ready, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    logic [DW-1:0] rd, rd2;
    logic          er;
    int            lt, brc, wnc;

    initial begin
        for (int i = 0; i < 16; i++) ram_init[i] = 8'($urandom);
        ram_init[7] = 8'h3C;
        ram_load = 1'b1;
        repeat (2) @(posedge clk);
        #1 ram_load = 1'b0;

        // Reset state
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_mar", mar, 4'h0);
        check("rst_bus_read", bus_read, 1'b0);
        check("rst_bus_write_n", bus_write_n, 1'b1);
        check("rst_bus_released", released(bus), 1'b1);
        check("rst_state", dbg_state, 3'd0);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Write 3 = A5
        do_txn(1'b1, 4'h3, 8'hA5, 0, rd, er, lt, brc, wnc);
        check("w3_latency", 32'(lt), READBACK ? 32'd5 : 32'd3);
        check("w3_bus_read_cycles", 32'(brc), 32'd1);
        check("w3_rdata", rd, 8'hA5);
        check("w3_err", er, 1'b0);
        check("w3_ram", ram_mem[3], 8'hA5);

        // Read 3 back
        do_txn(1'b0, 4'h3, 8'h00, 0, rd, er, lt, brc, wnc);
        check("r3_latency", 32'(lt), 32'd3);
        check("r3_write_n_low_cycles", 32'(wnc), 32'd2);
        check("r3_bus_read_cycles", 32'(brc), 32'd0);
        check("r3_rdata", rd, 8'hA5);

        // Read F = 5C with the response held off for 5 cycles
        do_txn(1'b1, 4'hF, 8'h5C, 0, rd, er, lt, brc, wnc);
        do_txn(1'b0, 4'hF, 8'h00, 5, rd, er, lt, brc, wnc);
        check("rF_rdata", rd, 8'h5C);
        check("rF_latency", 32'(lt), 32'd3);

        // Back-to-back write 0 = 11, read 0
        do_txn(1'b1, 4'h0, 8'h11, 0, rd, er, lt, brc, wnc);
        do_txn(1'b0, 4'h0, 8'h00, 0, rd2, er, lt, brc, wnc);
        check("b2b_wr_rdata", rd, 8'h11);
        check("b2b_rd_rdata", rd2, 8'h11);

        // Asynchronous reset in the middle of a write XFER to address 7
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h7; req_wdata = 8'hC3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_bus_read", bus_read, 1'b0);
        check("mid_rst_bus_write_n", bus_write_n, 1'b1);
        check("mid_rst_req_ready", req_ready, 1'b1);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_bus_released", released(bus), 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_ram7_unchanged", ram_mem[7], 8'h3C);
        exp_q.delete();

        // Address 2 with bit 0 stuck at 0, write FF
        stuck_en = 1'b1;
        do_txn(1'b1, 4'h2, 8'hFF, 0, rd, er, lt, brc, wnc);
        check("stuck_rdata", rd, READBACK ? 8'hFE : 8'hFF);
        check("stuck_err", er, READBACK ? 1'b1 : 1'b0);
        check("stuck_latency", 32'(lt), READBACK ? 32'd5 : 32'd3);
        stuck_en = 1'b0;

        // Randomized traffic, checked cycle by cycle against the model
        for (int t = 0; t < 40; t++) begin
            do_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
                   $urandom_range(0, 3), rd, er, lt, brc, wnc);
            repeat ($urandom_range(0, 2)) begin
                rsp_ready = 1'($urandom);
                @(posedge clk); #1;
            end
            rsp_ready = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1 chk_en = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete t=%0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
